demux_signal: RTL

Routes one asynchronous input signal to one of four outputs selected by a host-written channel register. It is the distribution-side counterpart of the 4:1 signal multiplexer. On a channel change it enforces a break-before-make dead time: all outputs are held at the idle level for a programmable number of clocks before the new channel is driven. It sits between the host register bus and external signal lines that must never see two channels active at once.

---
 rtl/demux_signal_pkg.sv | 21 ++
 rtl/signal_sync.sv | 22 ++
 rtl/demux_signal.sv | 103 ++++++++++
 3 files changed

// File: rtl/demux_signal_pkg.sv
// Shared types and constants for the 1:4 signal demultiplexer with
// break-before-make switching.
package demux_signal_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_DEAD   = 1'b1
  } state_e;

  localparam int CH_COUNT = 4;
  localparam int CH_W     = 2;

  typedef logic [CH_W-1:0] ch_t;

  // A channel request deferred by one cycle (write landing on the DEAD exit edge).
  typedef struct packed {
    logic vld;
    ch_t  ch;
  } ch_req_t;

endpackage

// File: rtl/signal_sync.sv
// Parameterized flop-chain synchronizer for a single asynchronous bit,
// with a configurable reset value so idle-high lines can be synced too.
module signal_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/demux_signal.sv
// Routes a synchronized input to one of CH_COUNT registered outputs, holding all
// outputs idle for DEAD_CYCLES clocks whenever the selected channel changes.
module demux_signal
  import demux_signal_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 4,
  parameter logic        IDLE_LEVEL  = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_i,
  input  logic [CH_W-1:0]     data_wr_i,
  input  logic                wr_i,
  output logic [CH_COUNT-1:0] out_o,
  output logic [CH_W-1:0]     sel_active_o,
  output logic                busy_o
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  logic                in_s;
  state_e              state_q, state_d;
  ch_t                 sel_q, sel_d;
  ch_t                 pending_q, pending_d;
  logic [7:0]          cnt_q, cnt_d;
  ch_req_t             req_q, req_d;
  logic [CH_COUNT-1:0] out_q, out_d;
  logic                wr_eff;
  ch_t                 wr_ch;

  signal_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (in_i),
    .q_o   (in_s)
  );

  // A live write outranks a deferred one: it is the more recent request.
  assign wr_eff = wr_i | req_q.vld;
  assign wr_ch  = wr_i ? data_wr_i : req_q.ch;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    case (state_q)
      ST_ACTIVE: begin
        req_d = '0;
        if (wr_eff && (wr_ch != sel_q)) begin
          pending_d = wr_ch;
          cnt_d     = DEAD_LOAD;
          state_d   = ST_DEAD;
        end
      end
      ST_DEAD: begin
        if (wr_i) pending_d = data_wr_i;
        if (cnt_q == 8'd0) begin
          sel_d   = pending_q;
          state_d = ST_ACTIVE;
          // Write on the exit edge cannot affect this switch; replay it next cycle.
          if (wr_i) req_d = '{vld: 1'b1, ch: data_wr_i};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Outputs come from next-state so the old channel drops on the triggering edge.
  for (genvar c = 0; c < CH_COUNT; c++) begin : g_lane
    assign out_d[c] = ((state_d == ST_ACTIVE) && (sel_d == CH_W'(c))) ? in_s : IDLE_LEVEL;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_ACTIVE;
      sel_q     <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      out_q     <= {CH_COUNT{IDLE_LEVEL}};
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      out_q     <= out_d;
    end
  end

  assign out_o        = out_q;
  assign sel_active_o = sel_q;
  assign busy_o       = (state_q == ST_DEAD);

endmodule
